prog_lut_neuron_loader: RTL

- Runtime-programmable truth-table neuron: a streaming loader writes the 2^IN_BITS x OUT_BITS table beat by beat, then the block serves registered lookups.
- Write-side counterpart to the fixed combinational neuron ROMs in the generated layers.
- Lets one netlist swap trained neuron functions without resynthesis.
- Sits between the config bus (host/DMA) and the layer datapath.

---
 rtl/prog_lut_pkg.sv | 27 ++
 rtl/prog_lut_store.sv | 54 +++++
 rtl/prog_lut_neuron_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/prog_lut_pkg.sv
// Shared types and derived sizes for the programmable LUT neuron loader.
// Holds the load FSM state enum and table geometry helper functions.
package prog_lut_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_t;

    function automatic int tbl_bits(input int ib, input int ob);
        return (1 << ib) * ob;
    endfunction

    function automatic int beats(input int ib, input int ob, input int lw);
        return tbl_bits(ib, ob) / lw;
    endfunction

    function automatic int ent_per_beat(input int ob, input int lw);
        return lw / ob;
    endfunction

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_lut_store.sv
// Beat-wide table storage with one write port and one registered lookup port.
// Lookup picks beat raddr/ENT_PER_BEAT and entry raddr%ENT_PER_BEAT.
module prog_lut_store
    import prog_lut_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int LOAD_W   = 16,
    localparam int BEATS   = beats(IN_BITS, OUT_BITS, LOAD_W),
    localparam int EPB     = ent_per_beat(OUT_BITS, LOAD_W),
    localparam int PW      = ptr_w(BEATS),
    localparam int EW      = ptr_w(EPB)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [PW-1:0]       waddr,
    input  logic [LOAD_W-1:0]   wdata,
    input  logic                re,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);

    logic [LOAD_W-1:0] mem [BEATS];
    logic [PW-1:0]     rbeat;
    logic [EW-1:0]     rent;
    logic [LOAD_W-1:0] rword;
    logic [LOAD_W-1:0] rshift;

    // Split the lookup address into beat row and entry column.
    always_comb begin
        rbeat  = PW'(int'(raddr) / EPB);
        rent   = EW'(int'(raddr) % EPB);
        rword  = mem[rbeat];
        rshift = rword >> (int'(rent) * OUT_BITS);
    end

    // Table rows are written whole; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds the last result when no lookup is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rshift[OUT_BITS-1:0];
        end
    end

endmodule

// File: rtl/prog_lut_neuron_loader.sv
// Runtime-programmable truth-table neuron: streaming table loader plus lookup.
// Optional checksum of loaded beats is enabled by defining PROG_LUT_CKSUM_EN.
module prog_lut_neuron_loader
    import prog_lut_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int LOAD_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [LOAD_W-1:0]   cfg_data,
    output logic                cfg_done,
    output logic                loaded,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic [LOAD_W-1:0]   cksum
);

    localparam int BEATS = beats(IN_BITS, OUT_BITS, LOAD_W);
    localparam int PW    = ptr_w(BEATS);
    localparam logic [PW-1:0] LAST = PW'(BEATS - 1);

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] ptr;
    logic          we;
    logic          last_hs;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: start always (re)enters LOADING; last beat finishes it.
    always_comb begin
        state_nx = state;
        if (cfg_start) begin
            state_nx = LOADING;
        end else begin
            unique case (state)
                EMPTY:   state_nx = EMPTY;
                LOADING: if (last_hs) state_nx = READY;
                READY:   state_nx = READY;
                default: state_nx = EMPTY;
            endcase
        end
    end

    // Outputs and handshake; start in the same cycle blocks acceptance.
    always_comb begin
        cfg_ready = (state == LOADING) && !cfg_start;
        loaded    = (state == READY);
        we        = cfg_valid && cfg_ready;
        last_hs   = we && (ptr == LAST);
    end

    // Beat pointer: cleared on start, advanced on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (cfg_start) begin
            ptr <= '0;
        end else if (we) begin
            ptr <= ptr + PW'(1);
        end
    end

    // Completion pulse lands with the rise of loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= last_hs;
        end
    end

    // Lookup valid follows the request by one cycle, only when loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid && loaded;
        end
    end

`ifdef PROG_LUT_CKSUM_EN
    logic [LOAD_W-1:0] ck_q;

    // Running XOR of accepted beats for the current load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ck_q <= '0;
        end else if (cfg_start) begin
            ck_q <= '0;
        end else if (we) begin
            ck_q <= ck_q ^ cfg_data;
        end
    end

    assign cksum = ck_q;
`else
    assign cksum = '0;
`endif

    prog_lut_store #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .LOAD_W   (LOAD_W)
    ) u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (ptr),
        .wdata (cfg_data),
        .re    (in_valid && loaded),
        .raddr (in_data),
        .rdata (out_data)
    );

endmodule
